spi_frame_collector: RTL



---
 rtl/spi_frame_collector_pkg.sv | 37 +++
 rtl/spi_in_sync.sv | 43 ++++
 rtl/spi_frame_collector.sv | 241 ++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_collector_pkg.sv
// rtl/spi_frame_collector_pkg.sv - shared types and helpers for the SPI frame collector
//
// Holds the de-framing FSM state encoding, the packet flag bit positions and
// the phase-sequencing helper used by the collector top.
package spi_frame_collector_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CMD   = 3'd1,
    ADDR  = 3'd2,
    DUMMY = 3'd3,
    DATA  = 3'd4,
    DONE  = 3'd5
  } state_e;

  localparam int FLAG_CMD   = 0;
  localparam int FLAG_ADDR  = 1;
  localparam int FLAG_DATA  = 2;
  localparam int FLAG_TRUNC = 3;

  // First phase strictly after 'cur' whose length is non-zero; DONE if none.
  // Lets zero-length phases be skipped in the same cycle.
  function automatic state_e next_phase(input state_e cur,
                                        input logic   cmd_nz,
                                        input logic   addr_nz,
                                        input logic   dummy_nz,
                                        input logic   data_nz);
    state_e nxt;
    nxt = DONE;
    if ((cur < DATA)  && data_nz)  nxt = DATA;
    if ((cur < DUMMY) && dummy_nz) nxt = DUMMY;
    if ((cur < ADDR)  && addr_nz)  nxt = ADDR;
    if ((cur < CMD)   && cmd_nz)   nxt = CMD;
    return nxt;
  endfunction

endpackage

// File: rtl/spi_in_sync.sv
// rtl/spi_in_sync.sv - 2-flop synchroniser with rise/fall edge detect
//
// Ports:
//   clk, rstn  system clock, async active-low reset
//   d          asynchronous input bus (W bits)
//   q          synchronised value
//   rise/fall  one-cycle pulses per bit on a synchronised 0->1 / 1->0 change
//
// All stages reset to 0. For the chip-selects this means a line held low
// through reset never looks like a falling edge, so a frame can only start
// after the bus has been seen idle (all high) following reset.
module spi_in_sync #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic [W-1:0] d,
  output logic [W-1:0] q,
  output logic [W-1:0] rise,
  output logic [W-1:0] fall
);

  logic [W-1:0] meta;
  logic [W-1:0] sync;
  logic [W-1:0] prev;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      meta <= '0;
      sync <= '0;
      prev <= '0;
    end else begin
      meta <= d;
      sync <= meta;
      prev <= sync;
    end
  end

  assign q    = sync;
  assign rise = sync & ~prev;
  assign fall = ~sync & prev;

endmodule

// File: rtl/spi_frame_collector.sv
// rtl/spi_frame_collector.sv - passive SPI bus monitor that de-frames CS windows into packets
//
// Ports:
//   clk, rstn                 system clock (>= 4x SCLK), async active-low reset
//   spi_sclk_i/csn_i/sdo_i    monitored SPI pins (CPOL=0, active-low CS, lane 0 = MOSI)
//   cfg_*_len_i, cfg_quad_i   phase lengths and quad select, latched at frame start
//   pkt_valid_o/pkt_ready_i   one-deep packet buffer handshake
//   pkt_cmd/addr/data_o       right-justified fields
//   pkt_cs_o, pkt_flag_o      chip-select index, {trunc, data, addr, cmd} seen flags
//   overflow_o, cs_err_o      one-cycle pulses: frame dropped / multiple CS at start
module spi_frame_collector
  import spi_frame_collector_pkg::*;
#(
  parameter int MAX_CMD_W  = 32,
  parameter int MAX_ADDR_W = 32,
  parameter int MAX_DATA_W = 64,
  parameter int NUM_CS     = 4,
  parameter int LANES      = 1
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            spi_sclk_i,
  input  logic [NUM_CS-1:0]               spi_csn_i,
  input  logic [LANES-1:0]                spi_sdo_i,
  input  logic [$clog2(MAX_CMD_W+1)-1:0]  cfg_cmd_len_i,
  input  logic [$clog2(MAX_ADDR_W+1)-1:0] cfg_addr_len_i,
  input  logic [15:0]                     cfg_dummy_len_i,
  input  logic [$clog2(MAX_DATA_W+1)-1:0] cfg_data_len_i,
  input  logic                            cfg_quad_i,
  output logic                            pkt_valid_o,
  input  logic                            pkt_ready_i,
  output logic [MAX_CMD_W-1:0]            pkt_cmd_o,
  output logic [MAX_ADDR_W-1:0]           pkt_addr_o,
  output logic [MAX_DATA_W-1:0]           pkt_data_o,
  output logic [$clog2(NUM_CS)-1:0]       pkt_cs_o,
  output logic [3:0]                      pkt_flag_o,
  output logic                            overflow_o,
  output logic                            cs_err_o
);

  localparam int CS_W    = $clog2(NUM_CS);
  localparam int CMD_LW  = $clog2(MAX_CMD_W+1);
  localparam int ADDR_LW = $clog2(MAX_ADDR_W+1);
  localparam int DATA_LW = $clog2(MAX_DATA_W+1);

  // Synchronised pins
  logic              sclk_q, sclk_rise, sclk_fall;
  logic [NUM_CS-1:0] csn_q, csn_rise, csn_fall, csn_prev;
  logic [LANES-1:0]  sdo_q, sdo_rise, sdo_fall;
  logic [3:0]        sdo4;
  logic              unused_sync;

  spi_in_sync #(.W(1)) u_sync_sclk (
    .clk(clk), .rstn(rstn), .d(spi_sclk_i), .q(sclk_q), .rise(sclk_rise), .fall(sclk_fall)
  );
  spi_in_sync #(.W(NUM_CS)) u_sync_csn (
    .clk(clk), .rstn(rstn), .d(spi_csn_i), .q(csn_q), .rise(csn_rise), .fall(csn_fall)
  );
  spi_in_sync #(.W(LANES)) u_sync_sdo (
    .clk(clk), .rstn(rstn), .d(spi_sdo_i), .q(sdo_q), .rise(sdo_rise), .fall(sdo_fall)
  );

  assign unused_sync = ^{sclk_q, sclk_fall, sdo_rise, sdo_fall};

  // Zero-extended so single-lane builds share the quad shift path; bit 3 is the MSB lane.
  assign sdo4 = 4'(sdo_q);

  // Previous-cycle CS levels recovered from the edge detector outputs.
  assign csn_prev = csn_q ^ (csn_rise | csn_fall);

  // Frame-start decode
  logic              frame_start, cs_multi, start_ok, start_err;
  logic [NUM_CS-1:0] cs_low;
  logic [CS_W-1:0]   cs_sel;

  assign cs_low      = ~csn_q;
  assign frame_start = (&csn_prev) & ~(&csn_q);
  assign cs_multi    = |(cs_low & (cs_low - NUM_CS'(1)));

  always_comb begin
    cs_sel = '0;
    for (int i = NUM_CS - 1; i >= 0; i--) begin
      if (cs_low[i]) cs_sel = CS_W'(i);
    end
  end

  // Latched frame context
  state_e             state_q, state_n;
  logic [CS_W-1:0]    cs_r;
  logic [CMD_LW-1:0]  cmd_len_r;
  logic [ADDR_LW-1:0] addr_len_r;
  logic [15:0]        dummy_len_r;
  logic [DATA_LW-1:0] data_len_r;
  logic               quad_r;
  logic [16:0]        cnt;
  logic [MAX_CMD_W-1:0]  cmd_sh;
  logic [MAX_ADDR_W-1:0] addr_sh;
  logic [MAX_DATA_W-1:0] data_sh;
  logic [3:0]         flag_r;
  logic               edges_seen;

  // Control decode
  logic        in_phase, cs_up, phase_hit, load, drop;
  logic [16:0] phase_len, cnt_inc;
  logic [2:0]  step;

  assign in_phase  = (state_q == CMD) || (state_q == ADDR) ||
                     (state_q == DUMMY) || (state_q == DATA);
  assign cs_up     = csn_q[cs_r];
  assign start_ok  = (state_q == IDLE) && frame_start && !cs_multi;
  assign start_err = (state_q == IDLE) && frame_start && cs_multi;

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_n;
  end

  // FSM: next state
  always_comb begin
    state_n = state_q;
    case (state_q)
      IDLE: begin
        if (start_ok)
          state_n = next_phase(IDLE, |cfg_cmd_len_i, |cfg_addr_len_i,
                               |cfg_dummy_len_i, |cfg_data_len_i);
      end
      CMD, ADDR, DUMMY, DATA: begin
        // A CS release before any SCLK edge is treated as if no frame occurred.
        if (cs_up)
          state_n = edges_seen ? DONE : IDLE;
        else if (sclk_rise && phase_hit)
          state_n = next_phase(state_q, |cmd_len_r, |addr_len_r,
                               |dummy_len_r, |data_len_r);
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // FSM: outputs / datapath control
  always_comb begin
    phase_len = '0;
    case (state_q)
      CMD:     phase_len = 17'(cmd_len_r);
      ADDR:    phase_len = 17'(addr_len_r);
      DUMMY:   phase_len = 17'(dummy_len_r);
      DATA:    phase_len = 17'(data_len_r);
      default: phase_len = '0;
    endcase
    step      = (quad_r && ((state_q == ADDR) || (state_q == DATA))) ? 3'd4 : 3'd1;
    cnt_inc   = cnt + 17'(step);
    // '>=' rounds quad phases up to whole nibbles.
    phase_hit = cnt_inc >= phase_len;
    load      = (state_q == DONE) && (!pkt_valid_o || pkt_ready_i);
    drop      = (state_q == DONE) && !load;
  end

  // Frame datapath
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cs_r        <= '0;
      cmd_len_r   <= '0;
      addr_len_r  <= '0;
      dummy_len_r <= '0;
      data_len_r  <= '0;
      quad_r      <= 1'b0;
      cnt         <= '0;
      cmd_sh      <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      flag_r      <= '0;
      edges_seen  <= 1'b0;
    end else if (start_ok) begin
      cs_r        <= cs_sel;
      cmd_len_r   <= cfg_cmd_len_i;
      addr_len_r  <= cfg_addr_len_i;
      dummy_len_r <= cfg_dummy_len_i;
      data_len_r  <= cfg_data_len_i;
      quad_r      <= (LANES == 4) && cfg_quad_i;
      cnt         <= '0;
      cmd_sh      <= '0;
      addr_sh     <= '0;
      data_sh     <= '0;
      flag_r      <= '0;
      edges_seen  <= 1'b0;
    end else if (in_phase) begin
      if (cs_up) begin
        flag_r[FLAG_TRUNC] <= 1'b1;
      end else if (sclk_rise) begin
        edges_seen <= 1'b1;
        cnt        <= (state_n != state_q) ? 17'd0 : cnt_inc;
        case (state_q)
          CMD: begin
            cmd_sh           <= {cmd_sh[MAX_CMD_W-2:0], sdo4[0]};
            flag_r[FLAG_CMD] <= 1'b1;
          end
          ADDR: begin
            addr_sh           <= quad_r ? {addr_sh[MAX_ADDR_W-5:0], sdo4}
                                        : {addr_sh[MAX_ADDR_W-2:0], sdo4[0]};
            flag_r[FLAG_ADDR] <= 1'b1;
          end
          DATA: begin
            data_sh           <= quad_r ? {data_sh[MAX_DATA_W-5:0], sdo4}
                                        : {data_sh[MAX_DATA_W-2:0], sdo4[0]};
            flag_r[FLAG_DATA] <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end

  // One-deep packet buffer and status pulses
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pkt_valid_o <= 1'b0;
      pkt_cmd_o   <= '0;
      pkt_addr_o  <= '0;
      pkt_data_o  <= '0;
      pkt_cs_o    <= '0;
      pkt_flag_o  <= '0;
      overflow_o  <= 1'b0;
      cs_err_o    <= 1'b0;
    end else begin
      overflow_o <= drop;
      cs_err_o   <= start_err;
      if (load) begin
        pkt_valid_o <= 1'b1;
        pkt_cmd_o   <= cmd_sh;
        pkt_addr_o  <= addr_sh;
        pkt_data_o  <= data_sh;
        pkt_cs_o    <= cs_r;
        pkt_flag_o  <= flag_r;
      end else if (pkt_ready_i) begin
        pkt_valid_o <= 1'b0;
      end
    end
  end

endmodule
